// File: rtl/combat_referee_pkg.sv
// Shared encodings, box layout and the hitbox/hurtbox overlap test used by
// the combat referee and its per-player stats blocks.
package combat_referee_pkg;

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_MOVEFORWARDS  = 4'd1,
        S_MOVEBACKWARDS = 4'd2,
        S_B_ATTACK_START= 4'd3,
        S_B_ATTACK_END  = 4'd4,
        S_B_ATTACK_PULL = 4'd5,
        S_D_ATTACK_START= 4'd6,
        S_D_ATTACK_END  = 4'd7,
        S_D_ATTACK_PULL = 4'd8,
        S_HITSTUN       = 4'd9,
        S_BLOCKSTUN     = 4'd10
    } player_state_e;

    typedef enum logic [1:0] {
        NOT_HIT            = 2'b00,
        HIT_BY_BASIC       = 2'b01,
        HIT_BY_DIRECTIONAL = 2'b10
    } hit_flag_e;

    localparam logic [1:0] ROUND_FIGHT     = 2'b00;
    localparam logic [1:0] ROUND_KO        = 2'b01;
    localparam logic [1:0] ROUND_GAME_OVER = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Box word layout: {x1, x2, y1, y2}, x1 in the top bits.
    localparam int FIELD_W = 10;
    localparam int X1_LSB  = 30;
    localparam int X2_LSB  = 20;
    localparam int Y1_LSB  = 10;
    localparam int Y2_LSB  = 0;

    function automatic logic boxes_overlap(input logic [39:0] a, input logic [39:0] b);
        logic [FIELD_W-1:0] ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
        ax1 = a[X1_LSB +: FIELD_W];
        ax2 = a[X2_LSB +: FIELD_W];
        ay1 = a[Y1_LSB +: FIELD_W];
        ay2 = a[Y2_LSB +: FIELD_W];
        bx1 = b[X1_LSB +: FIELD_W];
        bx2 = b[X2_LSB +: FIELD_W];
        by1 = b[Y1_LSB +: FIELD_W];
        by2 = b[Y2_LSB +: FIELD_W];
        return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
    endfunction

endpackage

// File: rtl/combat_referee_if.sv
// Player-facing bundle of the referee: player states and boxes in,
// hit flags, meters and round status out.
interface combat_referee_if;
    logic        restart;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_basic_box, p2_basic_box;
    logic [39:0] p1_dir_box, p2_dir_box;
    logic [39:0] p1_hurt_box, p2_hurt_box;
    logic [1:0]  p1_hitFlag, p2_hitFlag;
    logic [2:0]  p1_health, p2_health;
    logic [2:0]  p1_block, p2_block;
    logic [1:0]  round_state;
    logic [1:0]  winner;

    modport master (
        output restart, p1_state, p2_state, p1_basic_box, p2_basic_box,
               p1_dir_box, p2_dir_box, p1_hurt_box, p2_hurt_box,
        input  p1_hitFlag, p2_hitFlag, p1_health, p2_health,
               p1_block, p2_block, round_state, winner
    );

    modport slave (
        input  restart, p1_state, p2_state, p1_basic_box, p2_basic_box,
               p1_dir_box, p2_dir_box, p1_hurt_box, p2_hurt_box,
        output p1_hitFlag, p2_hitFlag, p1_health, p2_health,
               p1_block, p2_block, round_state, winner
    );
endinterface

// File: rtl/combat_referee_fighter_stats.sv
// Per-player meters: health, block meter with regen timer, and the one-cycle
// hit flag pulse seen by the victim.
module fighter_stats
    import combat_referee_pkg::*;
#(
    parameter int MAX_HEALTH  = 5,
    parameter int MAX_BLOCK   = 3,
    parameter int DMG_BASIC   = 1,
    parameter int DMG_DIR     = 2,
    parameter int BLOCK_REGEN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apply_hit,
    input  logic [1:0] hit_kind,
    input  logic       blocking,
    input  logic       freeze,
    input  logic       reload,
    output logic [2:0] health,
    output logic [2:0] block,
    output logic [2:0] health_next,
    output logic [1:0] hit_flag
);
    localparam int              RW         = $clog2(BLOCK_REGEN);
    localparam logic [2:0]      HMAX       = 3'(MAX_HEALTH);
    localparam logic [2:0]      BMAX       = 3'(MAX_BLOCK);
    localparam logic [RW-1:0]   REGEN_LAST = RW'(BLOCK_REGEN - 1);

    logic [RW-1:0] regen, regen_next;
    logic [2:0]    block_next;
    logic [1:0]    flag_next;
    logic [2:0]    dmg;

    assign dmg = (hit_kind == HIT_BY_DIRECTIONAL) ? 3'(DMG_DIR) : 3'(DMG_BASIC);

    // A blocked hit overrides a regen wrap landing on the same cycle.
    always_comb begin
        health_next = health;
        block_next  = block;
        regen_next  = regen;
        flag_next   = NOT_HIT;
        if (reload) begin
            health_next = HMAX;
            block_next  = BMAX;
            regen_next  = '0;
        end else if (!freeze) begin
            if (block < BMAX) begin
                if (regen == REGEN_LAST) begin
                    regen_next = '0;
                    block_next = block + 3'd1;
                end else begin
                    regen_next = regen + 1'b1;
                end
            end else begin
                regen_next = '0;
            end
            if (apply_hit) begin
                flag_next = hit_kind;
                if (blocking && block != 3'd0) begin
                    block_next = block - 3'd1;
                    regen_next = '0;
                end else begin
                    health_next = (health > dmg) ? health - dmg : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            health   <= HMAX;
            block    <= BMAX;
            regen    <= '0;
            hit_flag <= NOT_HIT;
        end else begin
            health   <= health_next;
            block    <= block_next;
            regen    <= regen_next;
            hit_flag <= flag_next;
        end
    end
endmodule

// File: rtl/combat_referee.sv
// Frame-rate hit arbiter between two players: one connect per swing,
// block/damage resolution and the round state machine.
//
// state           | meaning
// ROUND_FIGHT     | hits resolved, block regen running
// ROUND_KO        | a health hit 0; hits ignored, meters frozen for KO_HOLD cycles
// ROUND_GAME_OVER | meters frozen; restart reloads and returns to FIGHT
module combat_referee
    import combat_referee_pkg::*;
#(
    parameter int MAX_HEALTH  = 5,
    parameter int MAX_BLOCK   = 3,
    parameter int DMG_BASIC   = 1,
    parameter int DMG_DIR     = 2,
    parameter int BLOCK_REGEN = 60,
    parameter int KO_HOLD     = 120
) (
    input logic             clk,
    input logic             rst,
    combat_referee_if.slave bus
);
    localparam int KO_W = $clog2(KO_HOLD + 1);

    logic [1:0]      round_state, winner;
    logic [KO_W-1:0] ko_cnt;
    logic            fight, reload;
    logic            p1_basic_live, p1_dir_live, p2_basic_live, p2_dir_live;
    logic            p1_swinging, p2_swinging;
    logic            p1_latch, p2_latch;
    logic            p1_connect, p2_connect;
    logic [1:0]      p1_kind, p2_kind;
    logic [2:0]      p1_health_next, p2_health_next;

    assign fight  = (round_state == ROUND_FIGHT);
    assign reload = (round_state == ROUND_GAME_OVER) && bus.restart;

    assign p1_basic_live = (bus.p1_state == S_B_ATTACK_END) && boxes_overlap(bus.p1_basic_box, bus.p2_hurt_box);
    assign p1_dir_live   = (bus.p1_state == S_D_ATTACK_END) && boxes_overlap(bus.p1_dir_box, bus.p2_hurt_box);
    assign p2_basic_live = (bus.p2_state == S_B_ATTACK_END) && boxes_overlap(bus.p2_basic_box, bus.p1_hurt_box);
    assign p2_dir_live   = (bus.p2_state == S_D_ATTACK_END) && boxes_overlap(bus.p2_dir_box, bus.p1_hurt_box);

    assign p1_swinging = (bus.p1_state == S_B_ATTACK_END) || (bus.p1_state == S_D_ATTACK_END);
    assign p2_swinging = (bus.p2_state == S_B_ATTACK_END) || (bus.p2_state == S_D_ATTACK_END);

    assign p1_connect = fight && !p1_latch && (p1_basic_live || p1_dir_live);
    assign p2_connect = fight && !p2_latch && (p2_basic_live || p2_dir_live);
    assign p1_kind    = p1_dir_live ? HIT_BY_DIRECTIONAL : HIT_BY_BASIC;
    assign p2_kind    = p2_dir_live ? HIT_BY_DIRECTIONAL : HIT_BY_BASIC;

    // Latch re-arms only once the attacker leaves both active-window states.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            p1_latch <= 1'b0;
            p2_latch <= 1'b0;
        end else begin
            if (!p1_swinging)    p1_latch <= 1'b0;
            else if (p1_connect) p1_latch <= 1'b1;
            if (!p2_swinging)    p2_latch <= 1'b0;
            else if (p2_connect) p2_latch <= 1'b1;
        end
    end

    fighter_stats #(
        .MAX_HEALTH(MAX_HEALTH), .MAX_BLOCK(MAX_BLOCK), .DMG_BASIC(DMG_BASIC),
        .DMG_DIR(DMG_DIR), .BLOCK_REGEN(BLOCK_REGEN)
    ) u_p1_stats (
        .clk(clk), .rst(rst),
        .apply_hit(p2_connect), .hit_kind(p2_kind),
        .blocking(bus.p1_state == S_MOVEBACKWARDS),
        .freeze(!fight), .reload(reload),
        .health(bus.p1_health), .block(bus.p1_block),
        .health_next(p1_health_next), .hit_flag(bus.p1_hitFlag)
    );

    fighter_stats #(
        .MAX_HEALTH(MAX_HEALTH), .MAX_BLOCK(MAX_BLOCK), .DMG_BASIC(DMG_BASIC),
        .DMG_DIR(DMG_DIR), .BLOCK_REGEN(BLOCK_REGEN)
    ) u_p2_stats (
        .clk(clk), .rst(rst),
        .apply_hit(p1_connect), .hit_kind(p1_kind),
        .blocking(bus.p2_state == S_MOVEBACKWARDS),
        .freeze(!fight), .reload(reload),
        .health(bus.p2_health), .block(bus.p2_block),
        .health_next(p2_health_next), .hit_flag(bus.p2_hitFlag)
    );

    // KO and winner are decided from next-cycle health so they land with the hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_state <= ROUND_FIGHT;
            winner      <= WIN_NONE;
            ko_cnt      <= '0;
        end else begin
            case (round_state)
                ROUND_FIGHT: begin
                    if (p1_health_next == 3'd0 || p2_health_next == 3'd0) begin
                        round_state <= ROUND_KO;
                        winner      <= {p1_health_next == 3'd0, p2_health_next == 3'd0};
                        ko_cnt      <= KO_W'(KO_HOLD - 1);
                    end
                end
                ROUND_KO: begin
                    if (ko_cnt == '0) round_state <= ROUND_GAME_OVER;
                    else              ko_cnt      <= ko_cnt - 1'b1;
                end
                ROUND_GAME_OVER: begin
                    if (bus.restart) begin
                        round_state <= ROUND_FIGHT;
                        winner      <= WIN_NONE;
                    end
                end
                default: round_state <= ROUND_FIGHT;
            endcase
        end
    end

    assign bus.round_state = round_state;
    assign bus.winner      = winner;
endmodule

// File: tb/tb_combat_referee.sv
// Bench for combat_referee: directed round scenarios plus random play, all
// compared cycle by cycle against a frame-level behavioural model.
module tb_combat_referee;
    localparam int MAXH = 5, MAXB = 3, REGEN = 60, KOH = 120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    combat_referee_if bus();
    combat_referee dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    int m_health[2], m_block[2], m_regen[2], m_flag[2];
    bit m_latch[2];
    int m_round, m_winner, m_ko_left;

    logic [39:0] hurt_a, near_a, far_a;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [39:0] mk(input int x1, input int x2, input int y1, input int y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    function automatic bit ovl(input logic [39:0] a, input logic [39:0] b);
        int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
        ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
        bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
        return ax1 <= bx2 && bx1 <= ax2 && ay1 <= by2 && by1 <= ay2;
    endfunction

    task automatic model_new_round();
        for (int p = 0; p < 2; p++) begin
            m_health[p] = MAXH; m_block[p] = MAXB; m_regen[p] = 0;
            m_flag[p] = 0; m_latch[p] = 0;
        end
        m_round = 0; m_winner = 0; m_ko_left = 0;
    endtask

    task automatic model_step();
        int st[2], kind[2], old_blk;
        logic [39:0] bas[2], dr[2], hrt[2];
        st[0] = int'(bus.p1_state);  st[1] = int'(bus.p2_state);
        bas[0] = bus.p1_basic_box;   bas[1] = bus.p2_basic_box;
        dr[0]  = bus.p1_dir_box;     dr[1]  = bus.p2_dir_box;
        hrt[0] = bus.p1_hurt_box;    hrt[1] = bus.p2_hurt_box;
        if (rst) begin
            model_new_round();
            return;
        end
        for (int a = 0; a < 2; a++) begin
            kind[a] = 0;
            if (m_round == 0 && !m_latch[a]) begin
                if (st[a] == 4 && ovl(bas[a], hrt[1-a]))      kind[a] = 1;
                else if (st[a] == 7 && ovl(dr[a], hrt[1-a])) kind[a] = 2;
            end
            if (st[a] != 4 && st[a] != 7) m_latch[a] = 0;
            else if (kind[a] != 0)        m_latch[a] = 1;
        end
        m_flag[0] = 0; m_flag[1] = 0;
        if (m_round == 0) begin
            for (int v = 0; v < 2; v++) begin
                old_blk = m_block[v];
                if (m_block[v] < MAXB) begin
                    m_regen[v]++;
                    if (m_regen[v] == REGEN) begin m_regen[v] = 0; m_block[v]++; end
                end else m_regen[v] = 0;
                if (kind[1-v] != 0) begin
                    m_flag[v] = kind[1-v];
                    if (st[v] == 2 && old_blk > 0) begin
                        m_block[v] = old_blk - 1;
                        m_regen[v] = 0;
                    end else begin
                        m_health[v] -= (kind[1-v] == 2) ? 2 : 1;
                        if (m_health[v] < 0) m_health[v] = 0;
                    end
                end
            end
            if (m_health[0] == 0 || m_health[1] == 0) begin
                m_round   = 1;
                m_ko_left = KOH;
                m_winner  = (m_health[1] == 0 ? 1 : 0) + (m_health[0] == 0 ? 2 : 0);
            end
        end else if (m_round == 1) begin
            m_ko_left--;
            if (m_ko_left == 0) m_round = 2;
        end else if (bus.restart) begin
            model_new_round();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("p1_flag",   int'(bus.p1_hitFlag), m_flag[0]);
        chk("p2_flag",   int'(bus.p2_hitFlag), m_flag[1]);
        chk("p1_health", int'(bus.p1_health),  m_health[0]);
        chk("p2_health", int'(bus.p2_health),  m_health[1]);
        chk("p1_block",  int'(bus.p1_block),   m_block[0]);
        chk("p2_block",  int'(bus.p2_block),   m_block[1]);
        chk("round",     int'(bus.round_state), m_round);
        chk("winner",    int'(bus.winner),     m_winner);
    endtask

    task automatic set_state(input int p, input int s);
        if (p == 0) bus.p1_state = 4'(s);
        else        bus.p2_state = 4'(s);
    endtask

    task automatic set_boxes(input bit overlap);
        bus.p1_basic_box = overlap ? near_a : far_a;
        bus.p2_basic_box = overlap ? near_a : far_a;
        bus.p1_dir_box   = overlap ? near_a : far_a;
        bus.p2_dir_box   = overlap ? near_a : far_a;
        bus.p1_hurt_box  = hurt_a;
        bus.p2_hurt_box  = hurt_a;
    endtask

    task automatic do_reset();
        bus.p1_state = 4'd0; bus.p2_state = 4'd0; bus.restart = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic swing(input int atk, input int s);
        set_state(atk, s);
        tick();
        set_state(atk, 0);
        tick();
    endtask

    function automatic int rnd_state();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 2;
        if (r < 5) return 4;
        if (r < 8) return 7;
        return $urandom_range(0, 15);
    endfunction

    function automatic logic [39:0] rnd_box();
        int x, y;
        x = $urandom_range(0, 150);
        y = $urandom_range(0, 150);
        return mk(x, x + $urandom_range(0, 100), y, y + $urandom_range(0, 100));
    endfunction

    initial begin
        hurt_a = mk(100, 200, 100, 200);
        near_a = mk(150, 160, 150, 160);
        far_a  = mk(500, 510, 500, 510);
        set_boxes(1'b1);
        do_reset();
        chk("rst_health", int'(bus.p1_health), 5);
        chk("rst_block",  int'(bus.p2_block), 3);
        chk("rst_round",  int'(bus.round_state), 0);

        // one connect per swing
        set_state(0, 4);
        tick();
        chk("t1_flag", int'(bus.p2_hitFlag), 1);
        chk("t1_health", int'(bus.p2_health), 4);
        tick();
        chk("t1_once_flag", int'(bus.p2_hitFlag), 0);
        chk("t1_once_health", int'(bus.p2_health), 4);
        set_state(0, 0);
        tick();

        // blocking drains the meter, then damage goes through
        do_reset();
        set_state(1, 2);
        for (int i = 0; i < 3; i++) begin
            set_state(0, 7);
            tick();
            chk("t2_flag", int'(bus.p2_hitFlag), 2);
            chk("t2_block", int'(bus.p2_block), 2 - i);
            chk("t2_health", int'(bus.p2_health), 5);
            set_state(0, 0);
            tick();
        end
        set_state(0, 7);
        tick();
        chk("t2_unblocked", int'(bus.p2_health), 3);
        set_state(0, 0);
        set_state(1, 0);
        tick();

        // regen after 60 idle cycles, ceiling holds
        do_reset();
        set_state(1, 2);
        set_state(0, 4);
        tick();
        set_state(0, 0);
        repeat (59) tick();
        chk("t4_pre", int'(bus.p2_block), 2);
        tick();
        chk("t4_regen", int'(bus.p2_block), 3);
        repeat (10) tick();
        chk("t4_ceiling", int'(bus.p2_block), 3);

        // blocked hit on cycle 59 restarts the regen count
        do_reset();
        set_state(1, 2);
        set_state(0, 4);
        tick();
        set_state(0, 0);
        repeat (58) tick();
        set_state(0, 4);
        tick();
        chk("t4_late_block", int'(bus.p2_block), 1);
        set_state(0, 0);
        tick();
        chk("t4_no_incr", int'(bus.p2_block), 1);

        // trade KO
        do_reset();
        swing(0, 7); swing(0, 7);
        swing(1, 7); swing(1, 7);
        set_state(0, 4); set_state(1, 4);
        tick();
        chk("t3_p1_flag", int'(bus.p1_hitFlag), 1);
        chk("t3_p2_flag", int'(bus.p2_hitFlag), 1);
        chk("t3_p1_health", int'(bus.p1_health), 0);
        chk("t3_round", int'(bus.round_state), 1);
        chk("t3_winner", int'(bus.winner), 3);
        set_state(0, 0); set_state(1, 0);

        // KO hold, game over, restart
        do_reset();
        swing(0, 7); swing(0, 7);
        set_state(0, 7);
        tick();
        chk("t5_ko", int'(bus.round_state), 1);
        chk("t5_winner", int'(bus.winner), 1);
        for (int i = 0; i < 119; i++) begin
            set_state(0, (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 4 : 7));
            bus.restart = (i == 50);
            tick();
            chk("t5_ko_flag", int'(bus.p2_hitFlag), 0);
        end
        bus.restart = 1'b0;
        set_state(0, 0);
        chk("t5_ko_end", int'(bus.round_state), 1);
        tick();
        chk("t5_game_over", int'(bus.round_state), 2);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        chk("t5_restart_round", int'(bus.round_state), 0);
        chk("t5_restart_health", int'(bus.p2_health), 5);
        chk("t5_restart_winner", int'(bus.winner), 0);

        // reset mid-KO, then edge-touching boxes
        do_reset();
        swing(0, 7); swing(0, 7);
        set_state(0, 7);
        tick();
        set_state(0, 0);
        do_reset();
        chk("t6_health", int'(bus.p2_health), 5);
        chk("t6_round", int'(bus.round_state), 0);
        chk("t6_winner", int'(bus.winner), 0);
        bus.p2_hurt_box  = mk(50, 90, 0, 100);
        bus.p1_basic_box = mk(10, 49, 0, 100);
        set_state(0, 4);
        tick();
        chk("t6_gap", int'(bus.p2_hitFlag), 0);
        set_state(0, 0);
        tick();
        bus.p1_basic_box = mk(10, 50, 0, 100);
        set_state(0, 4);
        tick();
        chk("t6_touch", int'(bus.p2_hitFlag), 1);
        set_state(0, 0);
        tick();

        // random play
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) set_state(0, rnd_state());
            if ($urandom_range(0, 2) == 0) set_state(1, rnd_state());
            if ($urandom_range(0, 7) == 0) begin
                bus.p1_basic_box = rnd_box(); bus.p2_basic_box = rnd_box();
                bus.p1_dir_box   = rnd_box(); bus.p2_dir_box   = rnd_box();
                bus.p1_hurt_box  = rnd_box(); bus.p2_hurt_box  = rnd_box();
            end
            bus.restart = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/combat_referee.md
Name: combat_referee

Overview:
- Per-frame arbiter that owns hit resolution between the two player instances.
- Compares each player's active hitbox against the opponent's main hurtbox, enforces one connect per attack, and decides blocked vs. unblocked hits.
- Owns health and block meters, drives each player's hitFlag, health and block inputs, and runs the round FSM (fight, KO hold, game over, restart).
- Sits between the two player instances and the renderer/scoreboard.

Parameters:
- MAX_HEALTH, 5, health reload value (fits 3 bits).
- MAX_BLOCK, 3, block meter reload and ceiling (fits 3 bits).
- DMG_BASIC, 1, health lost per unblocked basic hit.
- DMG_DIR, 2, health lost per unblocked directional hit.
- BLOCK_REGEN, 60, cycles without a blocked hit before block gains +1.
- KO_HOLD, 120, cycles spent in KO before GAME_OVER.

Ports:
- clk  in  1  frame-rate clock shared with the players
- rst  in  1  synchronous, active-high reset
- restart  in  1  leave GAME_OVER and start a new round
- p1_state, p2_state  in  4 each  player current_state
- p1_basic_box, p2_basic_box  in  40 each  basic hitbox {x1,x2,y1,y2}, 10 bits per field
- p1_dir_box, p2_dir_box  in  40 each  directional hitbox {x1,x2,y1,y2}
- p1_hurt_box, p2_hurt_box  in  40 each  main hurtbox {x1,x2,y1,y2}
- p1_hitFlag, p2_hitFlag  out  2 each  00 none, 01 basic, 10 directional
- p1_health, p2_health  out  3 each  current health
- p1_block, p2_block  out  3 each  current block meter
- round_state  out  2  00 FIGHT, 01 KO, 10 GAME_OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset (sync, rst=1):
  - health = MAX_HEALTH, block = MAX_BLOCK.
  - hitFlags = 00, round_state = FIGHT, winner = 00.
  - Connect latches and regen counters cleared.
- Active windows:
  - Basic hitbox is live only in state 4 (B_ATTACK_END).
  - Directional hitbox is live only in state 7 (D_ATTACK_END).
  - No other state produces hits.
- Overlap test: inclusive on both axes, i.e. ax1<=bx2 && bx1<=ax2 && ay1<=by2 && by1<=ay2. Unsigned 10-bit compares.
- Connect (FIGHT only): attacker is in a live window, overlap is true, and the attacker's connect latch is clear.
  - On connect, set the latch.
  - Clear the latch on the first cycle the attacker is outside states 4 and 7. One connect per swing.
- Latency: inputs sampled at cycle N; the victim's hitFlag is 01/10 for exactly cycle N+1, then returns to 00. Health and block update at N+1.
- Block decision uses registered values at cycle N:
  - Victim state == 2 (MOVEBACKWARDS) and block > 0 → blocked. Block is decremented by 1, health is unchanged, and the victim's regen counter is zeroed.
  - Otherwise unblocked: health = health − DMG, saturating at 0.
- Trade: both players connecting in the same cycle are both applied. Both hitFlags pulse in the same cycle.
- Block regen:
  - While block < MAX_BLOCK and in FIGHT, the counter increments each cycle.
  - At BLOCK_REGEN−1 it wraps to 0 and block += 1.
  - The counter holds at 0 when block == MAX_BLOCK.
- Round FSM:
  - FIGHT → KO on the first cycle any health reaches 0. Winner is latched in the same update: P2 health 0 only → 01; P1 health 0 only → 10; both 0 (trade) → 11.
  - KO: no hits processed, hitFlags held at 00, regen frozen. After KO_HOLD cycles → GAME_OVER.
  - GAME_OVER: meters frozen. restart=1 → FIGHT next cycle with health/block reloaded, latches and counters cleared, winner = 00.
  - restart is ignored in FIGHT and KO.
- Reset mid-round or mid-KO: all values return to their reset values on the next edge. No partial state survives.
- Undefined player state codes (11–15) are treated as non-attacking, non-blocking.

Decomposition:
- Shared package (fighter_pkg):
  - Player state encodings S_IDLE..S_BLOCKSTUN.
  - hitFlag encodings notHit / hitByBasic / hitByDirectional.
  - round_state and winner encodings.
  - Box field slice offsets.
- Sub-module fighter_stats, instantiated once per player: holds health, block, regen counter and connect-pulse register. Inputs: apply_hit, hit_kind, blocking, freeze, reload.
- Overlap compare: a package function, not a module.

Test Plan:
1. P1 in state 4 overlapping P2 hurtbox, P2 idle, for 2 cycles → p2_hitFlag=01 for exactly 1 cycle; p2_health 5→4; no second hit while P1 stays in state 4.
2. P1 in state 7 overlapping; P2 in state 2 with block=3 → p2_hitFlag=10; p2_block=2; p2_health stays 5. Repeat until block=0, then the next hit → health 5→3.
3. Both players in state 4, mutually overlapping, with health 1 each → both hitFlags pulse the same cycle; both health 0; round_state=KO; winner=11.
4. P2 block=2, no further hits → after 60 cycles block=3 and it stays at 3. A blocked hit at cycle 59 resets the count; no increment at cycle 60.
5. P2 health driven to 0 by directional hits → KO for 120 cycles with hitFlags 00 despite overlap; then GAME_OVER. restart=1 → FIGHT with health=5, block=3, winner=00.
6. rst asserted during KO with health 0 → next cycle health=5, round_state=FIGHT, winner=00. Edge-touching boxes (x2 == opponent x1) register a hit.
